// File: rtl/addsub_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index register; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational ripple-carry chunk of SLICE bits.
// c_msb is the carry into the slice MSB, used for signed overflow detection.
module rca_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
  end

  assign cout  = w_c[SLICE];
  assign c_msb = w_c[SLICE-1];

endmodule

// File: rtl/multicycle_addsub.sv
// Sequential two's-complement adder/subtractor: WIDTH bits evaluated SLICE bits
// per clock, LSB slice first, with the carry held in a register between slices.
// Optional build macro RCS_SAT_EN: saturate the result to the signed limit on overflow.
module multicycle_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_w(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $fatal(1, "multicycle_addsub: WIDTH must be >= 2 and a multiple of SLICE");
  end

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        w_base;
  logic [SLICE-1:0]   w_sum;
  logic               w_slice_cout;
  logic               w_c_msb;
  logic               w_last;

`ifdef RCS_SAT_EN
  // Signed limit in the direction of the overflow, chosen by the sign of A.
  function automatic logic [WIDTH-1:0] sat_limit(input logic a_msb);
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign w_base = 32'(r_idx) * 32'(SLICE);
  assign w_last = (r_idx == LAST_IDX);

  rca_slice #(.SLICE(SLICE)) u_slice (
    .a     (r_a[w_base +: SLICE]),
    .b     (r_b[w_base +: SLICE]),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_slice_cout),
    .c_msb (w_c_msb)
  );

  // FSM state register; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on accept; B is pre-inverted for subtraction.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b ^ {WIDTH{sub}};
    end
  end

  // Slice-by-slice result assembly, carry chaining and flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry <= sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_s[w_base +: SLICE] <= w_sum;
          r_carry              <= w_slice_cout;
          r_idx                <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_slice_cout;
            r_ovf  <= w_slice_cout ^ w_c_msb;
`ifdef RCS_SAT_EN
            if (w_slice_cout ^ w_c_msb) r_s <= sat_limit(r_a[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub: three instances (SLICE 1, 4, 16) at WIDTH 16.
// Expected results come from a plain-arithmetic model of signed/unsigned add/sub.
module tb_multicycle_addsub;

  typedef struct {
    int          k;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [2:0]       in_valid_v, in_ready_v, sub_v, out_valid_v, out_ready_v;
  logic [2:0]       cout_v, ovf_v;
  logic [2:0][15:0] a_v, b_v, s_v;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   acc_edge [3];
  logic [2:0] vld_prev = '0;

  multicycle_addsub #(.WIDTH(16), .SLICE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .sub(sub_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  multicycle_addsub #(.WIDTH(16), .SLICE(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .sub(sub_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  multicycle_addsub #(.WIDTH(16), .SLICE(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int nsl(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 1;
  endfunction

  function automatic exp_t model(input int k, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    exp_t e;
    int   sa, sb, t;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    t   = sub ? (sa - sb) : (sa + sb);
    e.k = k;
    e.s = t[15:0];
    e.o = (t > 32767) || (t < -32768);
    e.c = sub ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > 65535);
`ifdef RCS_SAT_EN
    if (e.o) e.s = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: latency on each out_valid rise, scoreboard compare on each handshake.
  always begin
    @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      if (in_valid_v[k] && in_ready_v[k]) acc_edge[k] = cyc + 1;
      if (out_valid_v[k] && !vld_prev[k]) chk($sformatf("latency[%0d]", k), cyc - acc_edge[k], nsl(k));
      vld_prev[k] = out_valid_v[k];
      if (out_valid_v[k] && out_ready_v[k]) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output[%0d]: got s=%h, expected no result", k, s_v[k]);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instance", k, e.k);
          chk($sformatf("s[%0d]", k), s_v[k], e.s);
          chk($sformatf("cout[%0d]", k), cout_v[k], e.c);
          chk($sformatf("ovf[%0d]", k), ovf_v[k], e.o);
        end
      end
    end
  end

  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input bit push);
    bit ok;
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; sub_v[k] = sub; in_valid_v[k] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready_v[k]) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout[%0d]: in_ready stayed 0, expected 1", k);
    end else begin
      if (push) q.push_back(model(k, a, b, sub));
      @(posedge clk);
    end
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      out_ready_v[k] = ($urandom_range(0, 3) != 0);
      if (q.size() == 0 && in_ready_v[k]) done = 1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL done_timeout[%0d]: pending=%0d, expected 0", k, q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] hs;
    logic        hc, ho;
    bit          seen;

    rst = 1'b1;
    in_valid_v = '0; out_ready_v = '1; sub_v = '0; a_v = '0; b_v = '0;
    for (int k = 0; k < 3; k++) acc_edge[k] = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", out_valid_v[k], 0);
      chk("rst_in_ready", in_ready_v[k], 1);
      chk("rst_s", s_v[k], 0);
      chk("rst_cout", cout_v[k], 0);
      chk("rst_ovf", ovf_v[k], 0);
    end
    rst = 1'b0;

    // Directed boundary cases on every slice width
    for (int k = 0; k < 3; k++) begin
      issue(k, 16'hFFFF, 16'h0001, 1'b0, 1); wait_done(k);
      issue(k, 16'h0001, 16'h000C, 1'b1, 1); wait_done(k);
      issue(k, 16'h7FFF, 16'h0001, 1'b0, 1); wait_done(k);
      issue(k, 16'h8000, 16'h0001, 1'b1, 1); wait_done(k);
    end

    // Asynchronous reset during the second RUN cycle, then a clean operation
    issue(1, 16'h1234, 16'h4321, 1'b0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid_v[1], 0);
    chk("midrst_s", s_v[1], 0);
    chk("midrst_in_ready", in_ready_v[1], 1);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 16'h1234, 16'h4321, 1'b0, 1); wait_done(1);

    // Back-pressure in DONE: outputs hold while in_valid and a wiggle
    out_ready_v[1] = 1'b0;
    issue(1, 16'h4000, 16'h4000, 1'b0, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid_v[1]) seen = 1;
      else @(negedge clk);
    end
    chk("stall_reached_done", seen, 1);
    hs = s_v[1]; hc = cout_v[1]; ho = ovf_v[1];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid_v[1] = ~in_valid_v[1];
      a_v[1] = 16'($urandom);
      #3;
      chk("stall_s", s_v[1], hs);
      chk("stall_cout", cout_v[1], hc);
      chk("stall_ovf", ovf_v[1], ho);
      chk("stall_in_ready", in_ready_v[1], 0);
    end
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    out_ready_v[1] = 1'b1;
    @(negedge clk);
    #3;
    chk("release_in_ready", in_ready_v[1], 1);
    issue(1, 16'h00F0, 16'h0F0F, 1'b1, 1); wait_done(1);

    // Randomized sweep across all slice widths
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        issue(k, 16'($urandom), 16'($urandom), 1'($urandom), 1);
        wait_done(k);
      end
    end

    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL leftover_results: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
